// File: rtl/rr_demux_arbiter.sv
// Round-robin arbiter for four requesters sharing one 2-to-4 demux.
// Drives the demux select/enable directly; one turnaround cycle separates grants.
module rr_demux_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       en,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_GRANT = 2'b01;
  localparam logic [1:0] ST_TURN  = 2'b10;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_ZERO = CNT_W'(0);

  // First set request at or after the pointer, wrapping mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] win;
    win = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      win = r[idx] ? idx : win;
    end
    return win;
  endfunction

  logic [1:0]       state_r, state_s;
  logic [3:0]       grant_r, grant_s;
  logic [1:0]       sel_r, sel_s;
  logic             busy_r, busy_s;
  logic             en_r;
  logic [CNT_W-1:0] hold_r, hold_s;
  logic [1:0]       ptr_r, ptr_s;
  logic [1:0]       arb_s;
  logic             any_req_s;
  logic             release_s;

  assign arb_s     = rr_pick(req, ptr_r);
  assign any_req_s = |req;
  assign release_s = done | ~req[sel_r] | (hold_r == HOLD_MAX);

  // Next-state logic; TURN arbitrates on its exit edge exactly like IDLE.
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    sel_s   = sel_r;
    busy_s  = busy_r;
    hold_s  = hold_r;
    ptr_s   = ptr_r;
    case (state_r)
      ST_IDLE, ST_TURN: begin
        if (any_req_s) begin
          grant_s = 4'b0001 << arb_s;
          sel_s   = arb_s;
          busy_s  = 1'b1;
          hold_s  = HOLD_ONE;
          state_s = ST_GRANT;
        end else begin
          grant_s = 4'b0000;
          busy_s  = 1'b0;
          hold_s  = HOLD_ZERO;
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          ptr_s   = sel_r + 2'd1;
          grant_s = 4'b0000;
          busy_s  = 1'b1;
          hold_s  = HOLD_ZERO;
          state_s = ST_TURN;
        end else begin
          hold_s  = hold_r + HOLD_ONE;
        end
      end
      default: begin
        grant_s = 4'b0000;
        busy_s  = 1'b0;
        hold_s  = HOLD_ZERO;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      grant_r <= 4'b0000;
      sel_r   <= 2'b00;
      en_r    <= 1'b0;
      busy_r  <= 1'b0;
      hold_r  <= HOLD_ZERO;
      ptr_r   <= 2'b00;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      sel_r   <= sel_s;
      en_r    <= |grant_s;
      busy_r  <= busy_s;
      hold_r  <= hold_s;
      ptr_r   <= ptr_s;
    end
  end

  assign grant = grant_r;
  assign sel   = sel_r;
  assign en    = en_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_rr_demux_arbiter.sv
// Scoreboard bench for rr_demux_arbiter: driver queues hand-computed
// expectations, a monitor pops one per clock and compares.
module tb_rr_demux_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       en;
  logic       busy;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  rr_demux_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .done  (done),
    .grant (grant),
    .sel   (sel),
    .en    (en),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("grant", {4'h0, grant}, {4'h0, e.g});
        chk("sel",   {6'h0, sel},   {6'h0, e.s});
        chk("en",    {7'h0, en},    {7'h0, |e.g});
        chk("busy",  {7'h0, busy},  {7'h0, e.b});
      end
    end
  end

  task automatic drive(input logic [3:0] r, input logic d,
                       input logic [3:0] g, input logic [1:0] s, input logic b);
    exp_t e;
    @(negedge clk);
    req  = r;
    done = d;
    e.g = g;
    e.s = s;
    e.b = b;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    @(posedge clk);
    #3;
    if (sb_q.size() != 0) begin
      chk("drain", 8'(sb_q.size()), 8'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_grant", {4'h0, grant}, 8'h00);
    chk("rst_sel",   {6'h0, sel},   8'h00);
    chk("rst_en",    {7'h0, en},    8'h00);
    chk("rst_busy",  {7'h0, busy},  8'h00);
    @(negedge clk);
    reset = 1'b0;
    drive(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // Round robin with all requesting: 4 held cycles, 1 turnaround each
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) drive(4'b1111, 1'b0, 4'b0001 << k, 2'(k), 1'b1);
      drive(4'b1111, 1'b0, 4'b0000, 2'(k), 1'b1);
    end
    drive(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1);

    // done coincides with timeout: single release, pointer +1
    for (int c = 0; c < 3; c++) drive(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1);
    drive(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b1);
    drive(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1);

    // Request drop, then pointer 3 beats 0, then wrap to 0
    drive(4'b0100, 1'b0, 4'b0000, 2'd1, 1'b1);
    drive(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
    drive(4'b1001, 1'b0, 4'b0000, 2'd2, 1'b1);
    drive(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1);
    drive(4'b1001, 1'b1, 4'b0000, 2'd3, 1'b1);
    drive(4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1);
    drive(4'b0100, 1'b0, 4'b0000, 2'd0, 1'b1);
    drive(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
    drain();

    // Asynchronous reset mid-grant
    chk("pre_rst_grant", {4'h0, grant}, 8'h04);
    reset = 1'b1;
    #1;
    chk("arst_grant", {4'h0, grant}, 8'h00);
    chk("arst_en",    {7'h0, en},    8'h00);
    chk("arst_busy",  {7'h0, busy},  8'h00);
    @(posedge clk);
    #1;
    chk("rst_hold_grant", {4'h0, grant}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b0000;
    drive(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
    drive(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // Single requester with done pulse, re-granted after one turnaround
    drive(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1);
    drive(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1);
    drive(4'b0010, 1'b1, 4'b0000, 2'd1, 1'b1);
    drive(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1);
    drive(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1);
    drive(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0);
    drive(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, cycles=%0d", cyc);
    $fatal(1);
  end

endmodule
